// File: rtl/button_conditioner.sv
// Multi-channel input conditioner: 2-FF synchroniser, per-channel debounce FSM,
// registered level, one-cycle edge pulses and a one-shot long-press pulse.
//
// state          | meaning
// RELEASED       | debounced level idle, watching for active input
// SETTLE_PRESS   | input active, counting toward acceptance of press
// PRESSED        | debounced level active, watching for idle input
// SETTLE_RELEASE | input idle, counting toward acceptance of release
module button_conditioner #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   HOLD_CYCLES     = 100000000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] DB_OUT,
  output logic [WIDTH-1:0] PEDGE,
  output logic [WIDTH-1:0] NEDGE,
  output logic [WIDTH-1:0] LPRESS
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic          ACTIVE    = ~IDLE_LEVEL;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    SETTLE_PRESS,
    PRESSED,
    SETTLE_RELEASE
  } state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  state_t           state    [WIDTH];
  logic [DW-1:0]    deb_cnt  [WIDTH];
  logic [HW-1:0]    hold_cnt [WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1  <= {WIDTH{IDLE_LEVEL}};
      sync2  <= {WIDTH{IDLE_LEVEL}};
      DB_OUT <= {WIDTH{IDLE_LEVEL}};
      PEDGE  <= '0;
      NEDGE  <= '0;
      LPRESS <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i]    <= RELEASED;
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1 <= IN;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        PEDGE[i]  <= 1'b0;
        NEDGE[i]  <= 1'b0;
        LPRESS[i] <= 1'b0;

        case (state[i])
          RELEASED: begin
            if (sync2[i] == ACTIVE) begin
              state[i]   <= SETTLE_PRESS;
              deb_cnt[i] <= DEB_ONE;
            end
          end
          SETTLE_PRESS: begin
            if (sync2[i] == IDLE_LEVEL) begin
              state[i]   <= RELEASED;
              deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
              state[i]   <= PRESSED;
              deb_cnt[i] <= '0;
              DB_OUT[i]  <= ACTIVE;
              // pulses follow the logical value DB_OUT takes, not press/release
              PEDGE[i]   <= ACTIVE;
              NEDGE[i]   <= ~ACTIVE;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end
          PRESSED: begin
            if (sync2[i] == IDLE_LEVEL) begin
              state[i]   <= SETTLE_RELEASE;
              deb_cnt[i] <= DEB_ONE;
            end
          end
          SETTLE_RELEASE: begin
            if (sync2[i] == ACTIVE) begin
              state[i]   <= PRESSED;
              deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
              state[i]   <= RELEASED;
              deb_cnt[i] <= '0;
              DB_OUT[i]  <= IDLE_LEVEL;
              PEDGE[i]   <= IDLE_LEVEL;
              NEDGE[i]   <= ~IDLE_LEVEL;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i]   <= RELEASED;
            deb_cnt[i] <= '0;
          end
        endcase

        // saturating hold counter; the LAST compare can only hit once per press
        if (DB_OUT[i] == ACTIVE) begin
          if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + 1'b1;
          if (hold_cnt[i] == HOLD_LAST) LPRESS[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= '0;
        end
      end
    end
  end

endmodule
